// File: rtl/jpegls_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jpegls_pipe_pkg
//  Purpose  : Shared DEPTH bounds and occupancy-width helper for the elastic
//             pipeline register.
//  Revision : 1.0 - initial release
// ============================================================================
package jpegls_pipe_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;

    // Counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : One data+valid register of the elastic pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipe_reg
//  Purpose  : DEPTH-stage valid/ready pipeline with combinational backward
//             ready, bubble collapsing, flush and an occupancy counter.
//  Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg
    import jpegls_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          validIn,
    input  logic [WIDTH-1:0]              dataIn,
    output logic                          readyOut,
    output logic                          validOut,
    output logic [WIDTH-1:0]              dataOut,
    input  logic                          readyIn,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int                c_occ_w   = occ_width(DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_one = c_occ_w'(1);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_bad
        $error("elastic_pipe_reg: DEPTH out of range");
    end

    logic [DEPTH-1:0]   w_valid;
    logic [WIDTH-1:0]   w_data [DEPTH];
    logic [DEPTH-1:0]   w_adv;
    logic               w_clear;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_occ_w-1:0] r_occ;

    // Ready ripples from the output stage back to the input so bubbles collapse.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = enable & (~w_valid[DEPTH-1] | readyIn);
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = enable & (~w_valid[i] | w_adv[i+1]);
        end
    end

    assign w_clear    = reset | flush;
    assign readyOut   = w_adv[0] & ~flush & ~reset;
    assign w_in_xfer  = validIn & readyOut;
    assign w_out_xfer = validOut & readyIn & enable;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_stage_valid;
        logic [WIDTH-1:0] w_stage_data;

        if (gi == 0) begin : g_head
            // Without a transfer the head stage empties but keeps its old data.
            assign w_stage_valid = w_in_xfer;
            assign w_stage_data  = w_in_xfer ? dataIn : w_data[0];
        end else begin : g_body
            assign w_stage_valid = w_valid[gi-1];
            assign w_stage_data  = w_data[gi-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (w_clear),
            .i_load  (w_adv[gi]),
            .i_valid (w_stage_valid),
            .i_data  (w_stage_data),
            .o_valid (w_valid[gi]),
            .o_data  (w_data[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + c_occ_one;
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - c_occ_one;
        end
    end

    assign validOut  = w_valid[DEPTH-1];
    assign dataOut   = w_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire
